ex: RTL and testbench

- Execute stage of the 5-stage MIPS-style pipeline. Sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Single-cycle ops are combinational: logic, shift, add/sub/compare, and jump/branch link-address writeback.
- DIV/DIVU run in an internal 32-iteration restoring-division FSM. While it runs, the block raises a stall request to the pipeline controller.

---
 rtl/ex.sv | 244 ++++++++++++++++++++++++
 tb/tb_ex.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex.sv
// Execute stage: combinational ALU plus a multi-cycle restoring divider for DIV/DIVU.
// Optional macro EX_OVERFLOW_TRAP_EN adds ovassert_o and suppresses writeback on ADD/SUB overflow.
module ex #(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_address_i,
  input  logic        is_in_delayslot_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        is_in_delayslot_o,
  output logic        stallreq_o
`ifdef EX_OVERFLOW_TRAP_EN
  ,
  output logic        ovassert_o
`endif
);

  localparam int unsigned CntW = $clog2(DIV_ITERS) + 1;

  localparam logic [2:0] SelNop   = 3'b000;
  localparam logic [2:0] SelLogic = 3'b001;
  localparam logic [2:0] SelShift = 3'b010;
  localparam logic [2:0] SelArith = 3'b100;
  localparam logic [2:0] SelJump  = 3'b110;

  localparam logic [7:0] OpOr   = 8'b0010_0101;
  localparam logic [7:0] OpAnd  = 8'b0010_0100;
  localparam logic [7:0] OpXor  = 8'b0010_0110;
  localparam logic [7:0] OpNor  = 8'b0010_0111;
  localparam logic [7:0] OpSll  = 8'b0111_1100;
  localparam logic [7:0] OpSrl  = 8'b0000_0010;
  localparam logic [7:0] OpSra  = 8'b0000_0011;
  localparam logic [7:0] OpAdd  = 8'b0010_0000;
  localparam logic [7:0] OpAddu = 8'b0010_0001;
  localparam logic [7:0] OpSub  = 8'b0010_0010;
  localparam logic [7:0] OpSubu = 8'b0010_0011;
  localparam logic [7:0] OpSlt  = 8'b0010_1010;
  localparam logic [7:0] OpSltu = 8'b0010_1011;
  localparam logic [7:0] OpDiv  = 8'b0001_1010;
  localparam logic [7:0] OpDivu = 8'b0001_1011;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_st_e;

  div_st_e         st_q, st_d;
  logic [31:0]     dividend_q, dividend_d;  // shifts out dividend bits, shifts in quotient bits
  logic [31:0]     divisor_q, divisor_d;
  logic [32:0]     rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;

  logic        is_div, is_sdiv, div_stall;
  logic [31:0] op1_abs, op2_abs, sum, diff, quot_fix, rem_fix;
  logic [32:0] rem_shift, rem_diff;
  logic [4:0]  shamt;
  logic [31:0] logic_res, shift_res, arith_res, alu_res;
  logic        ov;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:4], stall[2:0]};

  assign is_div  = (aluop_i == OpDiv) || (aluop_i == OpDivu);
  assign is_sdiv = (aluop_i == OpDiv);
  assign op1_abs = (is_sdiv && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
  assign op2_abs = (is_sdiv && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

  assign rem_shift = {rem_q[31:0], dividend_q[31]};
  assign rem_diff  = rem_shift - {1'b0, divisor_q};

  always_comb begin
    st_d       = st_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_stall  = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (is_div) begin
          div_stall = 1'b1;
          cnt_d     = '0;
          rem_d     = '0;
          if (reg2_i == 32'd0) begin
            dividend_d = '0;
            divisor_d  = '0;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            st_d       = StDone;
          end else begin
            dividend_d = op1_abs;
            divisor_d  = op2_abs;
            neg_quot_d = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_d  = is_sdiv && reg1_i[31];
            st_d       = StBusy;
          end
        end
      end
      StBusy: begin
        div_stall = 1'b1;
        if (!rem_diff[32]) begin
          rem_d      = rem_diff;
          dividend_d = {dividend_q[30:0], 1'b1};
        end else begin
          rem_d      = rem_shift;
          dividend_d = {dividend_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DIV_ITERS - 1)) begin
          st_d = StDone;
        end
      end
      StDone: begin
        // Stay put while the stage is held so the same DIV cannot restart.
        if (!stall[3]) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign quot_fix = neg_quot_q ? (32'd0 - dividend_q) : dividend_q;
  assign rem_fix  = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

  assign sum   = reg1_i + reg2_i;
  assign diff  = reg1_i - reg2_i;
  assign shamt = reg1_i[4:0];

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    case (aluop_i)
      OpOr:  logic_res = reg1_i | reg2_i;
      OpAnd: logic_res = reg1_i & reg2_i;
      OpXor: logic_res = reg1_i ^ reg2_i;
      OpNor: logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
    case (aluop_i)
      OpSll: shift_res = reg2_i << shamt;
      OpSrl: shift_res = reg2_i >> shamt;
      OpSra: shift_res = $unsigned($signed(reg2_i) >>> shamt);
      default: shift_res = '0;
    endcase
    case (aluop_i)
      OpAdd, OpAddu: arith_res = sum;
      OpSub, OpSubu: arith_res = diff;
      OpSlt:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      OpSltu: arith_res = {31'd0, reg1_i < reg2_i};
      default: arith_res = '0;
    endcase
  end

  always_comb begin
    case (alusel_i)
      SelNop:   alu_res = '0;
      SelLogic: alu_res = logic_res;
      SelShift: alu_res = shift_res;
      SelArith: alu_res = arith_res;
      SelJump:  alu_res = link_address_i;
      default:  alu_res = '0;
    endcase
  end

`ifdef EX_OVERFLOW_TRAP_EN
  always_comb begin
    ov = 1'b0;
    if (alusel_i == SelArith) begin
      if (aluop_i == OpAdd) begin
        ov = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
      end else if (aluop_i == OpSub) begin
        ov = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
      end
    end
  end
`else
  assign ov = 1'b0;
`endif

  // Every output is held at zero for as long as reset is asserted.
  always_comb begin
    wd_o              = wd_i;
    wreg_o            = wreg_i && !is_div && !ov;
    wdata_o           = is_div ? 32'd0 : alu_res;
    whilo_o           = (st_q == StDone);
    hi_o              = (st_q == StDone) ? rem_fix : 32'd0;
    lo_o              = (st_q == StDone) ? quot_fix : 32'd0;
    is_in_delayslot_o = is_in_delayslot_i;
    stallreq_o        = div_stall;
`ifdef EX_OVERFLOW_TRAP_EN
    ovassert_o        = ov;
`endif
    if (!rst) begin
      wd_o              = '0;
      wreg_o            = 1'b0;
      wdata_o           = '0;
      whilo_o           = 1'b0;
      hi_o              = '0;
      lo_o              = '0;
      is_in_delayslot_o = 1'b0;
      stallreq_o        = 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
      ovassert_o        = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the execute stage: ALU ops, divider timing/hold, reset abort,
// and add/sub overflow handling with or without EX_OVERFLOW_TRAP_EN.
module tb_ex;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i, link_address_i;
  logic [4:0]  wd_i;
  logic        wreg_i, is_in_delayslot_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, is_in_delayslot_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;
`ifdef EX_OVERFLOW_TRAP_EN
  logic        ovassert_o;
`endif

  int checks = 0;
  int errors = 0;

  ex dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .aluop_i           (aluop_i),
    .alusel_i          (alusel_i),
    .reg1_i            (reg1_i),
    .reg2_i            (reg2_i),
    .wd_i              (wd_i),
    .wreg_i            (wreg_i),
    .link_address_i    (link_address_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .wd_o              (wd_o),
    .wreg_o            (wreg_o),
    .wdata_o           (wdata_o),
    .whilo_o           (whilo_o),
    .hi_o              (hi_o),
    .lo_o              (lo_o),
    .is_in_delayslot_o (is_in_delayslot_o),
    .stallreq_o        (stallreq_o)
`ifdef EX_OVERFLOW_TRAP_EN
    ,
    .ovassert_o        (ovassert_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    aluop_i  = 8'h00;
    alusel_i = 3'b000;
    reg1_i   = '0;
    reg2_i   = '0;
    wd_i     = '0;
    wreg_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall = '0;
    aluop_i = 8'b0010_0101;
    alusel_i = 3'b001;
    reg1_i = 32'h0000_F0F0;
    reg2_i = 32'h00FF_00FF;
    wd_i = 5'd9;
    wreg_i = 1'b1;
    link_address_i = 32'h1234_5678;
    is_in_delayslot_i = 1'b1;
    #3;
    checks++; if (wdata_o !== 32'd0) begin errors++;
      $display("FAIL reset wdata got %h want 0", wdata_o); end
    checks++; if (wd_o !== 5'd0 || wreg_o !== 1'b0) begin errors++;
      $display("FAIL reset wd/wreg got %h/%b want 0/0", wd_o, wreg_o); end
    checks++; if (whilo_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++;
      $display("FAIL reset hilo got %b %h %h want 0 0 0", whilo_o, hi_o, lo_o); end
    checks++; if (stallreq_o !== 1'b0 || is_in_delayslot_o !== 1'b0) begin errors++;
      $display("FAIL reset stall/ds got %b/%b want 0/0", stallreq_o, is_in_delayslot_o); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (wdata_o !== 32'h00FF_F0FF || wd_o !== 5'd9 || wreg_o !== 1'b1) begin errors++;
      $display("FAIL post_reset_or got %h/%h/%b want 00fff0ff/09/1", wdata_o, wd_o, wreg_o); end
  endtask

  typedef struct packed {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_alu();
    vec_t v [15];
    v = '{
      '{8'h25, 3'b001, 32'h0000_F0F0, 32'h00FF_00FF, 32'h00FF_F0FF},
      '{8'h24, 3'b001, 32'h0000_F0F0, 32'h00FF_00FF, 32'h0000_00F0},
      '{8'h26, 3'b001, 32'h0000_F0F0, 32'h00FF_00FF, 32'h00FF_F00F},
      '{8'h27, 3'b001, 32'h0000_F0F0, 32'h00FF_00FF, 32'hFF00_0F00},
      '{8'h7C, 3'b010, 32'h0000_0004, 32'h8000_0010, 32'h0000_0100},
      '{8'h7C, 3'b010, 32'h0000_001F, 32'h0000_0003, 32'h8000_0000},
      '{8'h02, 3'b010, 32'h0000_0004, 32'h8000_0010, 32'h0800_0001},
      '{8'h03, 3'b010, 32'h0000_0004, 32'h8000_0010, 32'hF800_0001},
      '{8'h03, 3'b010, 32'hFFFF_FFE4, 32'h8000_0010, 32'hF800_0001},
      '{8'h21, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
      '{8'h23, 3'b100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
      '{8'h2A, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
      '{8'h2B, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
      '{8'h00, 3'b110, 32'h0000_0003, 32'h0000_0004, 32'h1234_5678},
      '{8'h25, 3'b000, 32'h0000_F0F0, 32'h00FF_00FF, 32'h0000_0000}
    };
    link_address_i = 32'h1234_5678;
    stall = '0;
    for (int i = 0; i < 15; i++) begin
      aluop_i = v[i].op;
      alusel_i = v[i].sel;
      reg1_i = v[i].a;
      reg2_i = v[i].b;
      wd_i = 5'(i + 1);
      wreg_i = 1'b1;
      is_in_delayslot_i = i[0];
      #1;
      checks++; if (wdata_o !== v[i].exp) begin errors++;
        $display("FAIL alu[%0d] wdata got %h want %h", i, wdata_o, v[i].exp); end
      checks++; if (wd_o !== 5'(i + 1) || wreg_o !== 1'b1) begin errors++;
        $display("FAIL alu[%0d] wd/wreg got %h/%b want %h/1", i, wd_o, wreg_o, 5'(i + 1)); end
      checks++; if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin errors++;
        $display("FAIL alu[%0d] stall/whilo got %b/%b want 0/0", i, stallreq_o, whilo_o); end
      checks++; if (is_in_delayslot_o !== i[0]) begin errors++;
        $display("FAIL alu[%0d] delayslot got %b want %b", i, is_in_delayslot_o, i[0]); end
      tick();
    end
    is_in_delayslot_i = 1'b0;
  endtask

  task automatic test_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_stall, input int hold);
    int n;
    aluop_i = op;
    alusel_i = 3'b000;
    reg1_i = a;
    reg2_i = b;
    wd_i = 5'd7;
    wreg_i = 1'b1;
    stall = '0;
    #1;
    n = 0;
    while (stallreq_o === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checks++; if (n !== exp_stall) begin errors++;
      $display("FAIL div %h/%h stall_cycles got %0d want %0d", a, b, n, exp_stall); end
    checks++; if (whilo_o !== 1'b1 || lo_o !== exp_lo || hi_o !== exp_hi) begin errors++;
      $display("FAIL div %h/%h result got whilo=%b lo=%h hi=%h want 1 %h %h",
               a, b, whilo_o, lo_o, hi_o, exp_lo, exp_hi); end
    checks++; if (wreg_o !== 1'b0 || wdata_o !== 32'd0) begin errors++;
      $display("FAIL div %h/%h wreg/wdata got %b/%h want 0/0", a, b, wreg_o, wdata_o); end
    stall = 6'b001000;
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if (whilo_o !== 1'b1 || lo_o !== exp_lo || hi_o !== exp_hi || stallreq_o !== 1'b0) begin
        errors++;
        $display("FAIL div_hold[%0d] got whilo=%b lo=%h hi=%h stall=%b want 1 %h %h 0",
                 k, whilo_o, lo_o, hi_o, stallreq_o, exp_lo, exp_hi);
      end
    end
    stall = '0;
    tick();
    set_nop();
    #1;
    checks++; if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin errors++;
      $display("FAIL div_release whilo/stall got %b/%b want 0/0", whilo_o, stallreq_o); end
  endtask

  task automatic test_reset_abort();
    aluop_i = 8'b0001_1011;
    alusel_i = 3'b000;
    reg1_i = 32'd100;
    reg2_i = 32'd7;
    wd_i = 5'd4;
    wreg_i = 1'b1;
    stall = '0;
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++;
      $display("FAIL abort_issue stall got %b want 1", stallreq_o); end
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b0;
    #1;
    checks++; if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0)
    begin errors++;
      $display("FAIL abort_outputs stall=%b whilo=%b hi=%h lo=%h want all 0",
               stallreq_o, whilo_o, hi_o, lo_o); end
    checks++; if (wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata_o !== 32'd0) begin errors++;
      $display("FAIL abort_wb wd=%h wreg=%b wdata=%h want all 0", wd_o, wreg_o, wdata_o); end
    aluop_i = 8'b0010_0001;
    alusel_i = 3'b100;
    reg1_i = 32'd1;
    reg2_i = 32'd1;
    wd_i = 5'd3;
    wreg_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wdata_o !== 32'd2 || wreg_o !== 1'b1 || wd_o !== 5'd3) begin errors++;
      $display("FAIL abort_addu got %h/%b/%h want 2/1/3", wdata_o, wreg_o, wd_o); end
    checks++; if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin errors++;
      $display("FAIL abort_addu stall/whilo got %b/%b want 0/0", stallreq_o, whilo_o); end
    tick();
    checks++; if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || wdata_o !== 32'd2) begin errors++;
      $display("FAIL abort_next stall=%b whilo=%b wdata=%h want 0 0 2",
               stallreq_o, whilo_o, wdata_o); end
    set_nop();
  endtask

  task automatic test_overflow();
    alusel_i = 3'b100;
    wd_i = 5'd6;
    wreg_i = 1'b1;
    aluop_i = 8'b0010_0000;
    reg1_i = 32'h7FFF_FFFF;
    reg2_i = 32'd1;
    #1;
`ifdef EX_OVERFLOW_TRAP_EN
    checks++; if (ovassert_o !== 1'b1 || wreg_o !== 1'b0) begin errors++;
      $display("FAIL ov_add ov/wreg got %b/%b want 1/0", ovassert_o, wreg_o); end
`else
    checks++; if (wdata_o !== 32'h8000_0000 || wreg_o !== 1'b1) begin errors++;
      $display("FAIL ov_add wdata/wreg got %h/%b want 80000000/1", wdata_o, wreg_o); end
`endif
    aluop_i = 8'b0010_0010;
    reg1_i = 32'h8000_0000;
    reg2_i = 32'd1;
    #1;
`ifdef EX_OVERFLOW_TRAP_EN
    checks++; if (ovassert_o !== 1'b1 || wreg_o !== 1'b0) begin errors++;
      $display("FAIL ov_sub ov/wreg got %b/%b want 1/0", ovassert_o, wreg_o); end
`else
    checks++; if (wdata_o !== 32'h7FFF_FFFF || wreg_o !== 1'b1) begin errors++;
      $display("FAIL ov_sub wdata/wreg got %h/%b want 7fffffff/1", wdata_o, wreg_o); end
`endif
    aluop_i = 8'b0010_0001;
    reg1_i = 32'h7FFF_FFFF;
    reg2_i = 32'd1;
    #1;
    checks++; if (wdata_o !== 32'h8000_0000 || wreg_o !== 1'b1) begin errors++;
      $display("FAIL ov_addu wdata/wreg got %h/%b want 80000000/1", wdata_o, wreg_o); end
`ifdef EX_OVERFLOW_TRAP_EN
    checks++; if (ovassert_o !== 1'b0) begin errors++;
      $display("FAIL ov_addu ovassert got %b want 0", ovassert_o); end
`endif
    tick();
    set_nop();
  endtask

  initial begin
    set_nop();
    test_reset();
    tick();
    test_alu();
    test_div(8'b0001_1010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1);
    test_div(8'b0001_1011, 32'd5, 32'd0, 32'd0, 32'd0, 1, 3);
    test_div(8'b0001_1010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1);
    test_div(8'b0001_1010, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1);
    test_div(8'b0001_1011, 32'd100, 32'd7, 32'd14, 32'd2, 33, 2);
    test_div(8'b0001_1011, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 1);
    test_reset_abort();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
